sqrt_nr_unit: RTL and testbench



---
 rtl/mdr_pkg.sv | 11 +
 rtl/sqrt_nr_step.sv | 52 +++++
 rtl/sqrt_nr_unit.sv | 131 +++++++++++++
 tb/tb_sqrt_nr_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// Shared types and constants for the MDR arithmetic cluster.
package mdr_pkg;
  localparam int MDR_SQRT_DW = 16;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} sqrt_state_e;

  // Width of the signed partial remainder and of the add/sub path.
  function automatic int sqrt_w(input int dw);
    return dw / 2 + 2;
  endfunction
endpackage

// File: rtl/sqrt_nr_step.sv
// One non-restoring square-root step (fix_mode=0) or the final remainder correction (fix_mode=1).
// Purely combinational; a single adder/subtractor serves both modes.
module sqrt_nr_step
  import mdr_pkg::*;
#(
  parameter int DW = MDR_SQRT_DW
) (
  input  logic [sqrt_w(DW)-1:0] r,
  input  logic [DW/2-1:0]       q,
  input  logic [1:0]            p,
  input  logic                  fix_mode,
  output logic [sqrt_w(DW)-1:0] r_next,
  output logic [DW/2-1:0]       q_next
);
  localparam int W = sqrt_w(DW);

  logic         r_neg;
  logic         sub;
  logic [W-1:0] a_op;
  logic [W-1:0] b_op;
  logic [W-1:0] sum;

  assign r_neg = r[W-1];

  always_comb begin
    a_op   = '0;
    b_op   = '0;
    sub    = 1'b0;
    r_next = r;
    q_next = q;
    if (fix_mode) begin
      a_op = r;
      b_op = {1'b0, q, 1'b1};
    end else begin
      a_op = {r[W-3:0], p};
      if (r_neg) begin
        b_op = {q, 2'b11};
      end else begin
        b_op = {q, 2'b01};
        sub  = 1'b1;
      end
    end
    sum = sub ? (a_op - b_op) : (a_op + b_op);
    if (fix_mode) begin
      // A negative final remainder is restored; a non-negative one is already exact.
      r_next = r_neg ? sum : r;
    end else begin
      r_next = sum;
      q_next = {q[DW/2-2:0], ~sum[W-1]};
    end
  end
endmodule

// File: rtl/sqrt_nr_unit.sv
// Non-restoring integer square root: start accepted in IDLE/DONE, done pulses DW/2+2 cycles later.
// start is ignored while busy; a negative operand in signed mode finishes next cycle with err.
module sqrt_nr_unit
  import mdr_pkg::*;
#(
  parameter int DW        = MDR_SQRT_DW,
  parameter bit SIGNED_IN = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] data,
  output logic [DW/2-1:0] result,
  output logic [DW/2:0]   remainder,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int HW = DW / 2;
  localparam int W  = sqrt_w(DW);
  localparam int CW = (HW > 1) ? $clog2(HW) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(HW - 1);

  generate
    if ((DW % 2) != 0 || DW < 4) begin : g_bad_dw
      $error("sqrt_nr_unit: DW must be even and at least 4");
    end
  endgenerate

  sqrt_state_e   state_q, state_d;
  logic [DW-1:0] d_q, d_d;
  logic [HW-1:0] q_q, q_d;
  logic [W-1:0]  r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] result_q, result_d;
  logic [HW:0]   remainder_q, remainder_d;
  logic          err_q, err_d;

  logic [1:0]    pair;
  logic          fix_mode;
  logic          neg_in;
  logic [W-1:0]  step_r;
  logic [HW-1:0] step_q;

  assign pair     = d_q[{cnt_q, 1'b0} +: 2];
  assign fix_mode = (state_q == FIX);
  assign neg_in   = SIGNED_IN && data[DW-1];

  sqrt_nr_step #(.DW(DW)) u_step (
    .r        (r_q),
    .q        (q_q),
    .p        (pair),
    .fix_mode (fix_mode),
    .r_next   (step_r),
    .q_next   (step_q)
  );

  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    q_d         = q_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    err_d       = err_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (neg_in) begin
            state_d     = DONE;
            result_d    = '0;
            remainder_d = '0;
            err_d       = 1'b1;
          end else begin
            state_d = CALC;
            d_d     = data;
            q_d     = '0;
            r_d     = '0;
            cnt_d   = CNT_TOP;
            err_d   = 1'b0;
          end
        end
      end
      CALC: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        r_d         = step_r;
        result_d    = q_q;
        remainder_d = step_r[W-2:0];
        state_d     = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      d_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      q_q         <= q_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      err_q       <= err_d;
    end
  end

  assign result    = result_q;
  assign remainder = remainder_q;
  assign err       = err_q;
  assign busy      = (state_q == CALC) || (state_q == FIX);
  assign done      = (state_q == DONE);
endmodule

// File: tb/tb_sqrt_nr_unit.sv
// Self-checking bench: 16-bit unsigned (inst 0), 32-bit unsigned (inst 1), 16-bit signed (inst 2).
module tb_sqrt_nr_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c;
  logic        start_a, start_b, start_c;
  logic [15:0] data_a, data_c;
  logic [31:0] data_b;
  logic [7:0]  res_a, res_c;
  logic [8:0]  rem_a, rem_c;
  logic [15:0] res_b;
  logic [16:0] rem_b;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, err_a, err_b, err_c;

  sqrt_nr_unit #(.DW(16), .SIGNED_IN(1'b0)) u_a (
    .clk(clk), .rst(rst_a), .start(start_a), .data(data_a), .result(res_a),
    .remainder(rem_a), .busy(busy_a), .done(done_a), .err(err_a));
  sqrt_nr_unit #(.DW(32), .SIGNED_IN(1'b0)) u_b (
    .clk(clk), .rst(rst_b), .start(start_b), .data(data_b), .result(res_b),
    .remainder(rem_b), .busy(busy_b), .done(done_b), .err(err_b));
  sqrt_nr_unit #(.DW(16), .SIGNED_IN(1'b1)) u_c (
    .clk(clk), .rst(rst_c), .start(start_c), .data(data_c), .result(res_c),
    .remainder(rem_c), .busy(busy_c), .done(done_c), .err(err_c));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          inst;
    logic [31:0] din;
    longint      res;
    longint      rem;
    bit          err;
  } vec_t;
  vec_t tbl[$];

  int     b2b_cyc[3] = '{10, 20, 30};
  longint b2b_res[3] = '{9, 10, 10};
  longint b2b_rem[3] = '{18, 0, 1};

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Floor square root by binary search on plain integers.
  function automatic longint isqrt(input longint x);
    longint lo = 0;
    longint hi = 65536;
    longint mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  task automatic drive(input int inst, input bit s, input logic [31:0] d);
    case (inst)
      0: begin start_a = s; data_a = d[15:0]; end
      1: begin start_b = s; data_b = d;       end
      default: begin start_c = s; data_c = d[15:0]; end
    endcase
  endtask

  function automatic longint g_res(input int inst);
    case (inst)
      0: return longint'(res_a);
      1: return longint'(res_b);
      default: return longint'(res_c);
    endcase
  endfunction
  function automatic longint g_rem(input int inst);
    case (inst)
      0: return longint'(rem_a);
      1: return longint'(rem_b);
      default: return longint'(rem_c);
    endcase
  endfunction
  function automatic bit g_busy(input int inst);
    case (inst)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction
  function automatic bit g_done(input int inst);
    case (inst)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction
  function automatic bit g_err(input int inst);
    case (inst)
      0: return err_a;
      1: return err_b;
      default: return err_c;
    endcase
  endfunction

  // One operation: start in cycle 0, then watch latency, busy, outputs and hold behaviour.
  task automatic op(input int inst, input logic [31:0] din, input longint er,
                    input longint erm, input bit ee, input string nm);
    int exp_cyc;
    int done_cyc;
    bit busy_bad;
    exp_cyc  = ee ? 1 : ((inst == 1) ? 18 : 10);
    done_cyc = -1;
    busy_bad = 1'b0;
    @(negedge clk);
    drive(inst, 1'b1, din);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) drive(inst, 1'b0, $urandom);
      if (g_done(inst)) begin
        done_cyc = c;
        break;
      end
      if (!g_busy(inst)) busy_bad = 1'b1;
    end
    chk({nm, " done_cycle"}, done_cyc, exp_cyc);
    chk({nm, " busy_in_flight"}, longint'(busy_bad), 0);
    chk({nm, " busy_at_done"}, longint'(g_busy(inst)), 0);
    chk({nm, " result"}, g_res(inst), er);
    chk({nm, " remainder"}, g_rem(inst), erm);
    chk({nm, " err"}, longint'(g_err(inst)), longint'(ee));
    chk({nm, " rem_bound"}, longint'(g_rem(inst) <= 2 * g_res(inst)), 1);
    @(posedge clk);
    #1;
    chk({nm, " done_one_cycle"}, longint'(g_done(inst)), 0);
    chk({nm, " result_hold"}, g_res(inst), er);
    chk({nm, " remainder_hold"}, g_rem(inst), erm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [31:0] v;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    data_a = '0; data_b = '0; data_c = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset%0d result", i), g_res(i), 0);
      chk($sformatf("reset%0d remainder", i), g_rem(i), 0);
      chk($sformatf("reset%0d busy", i), longint'(g_busy(i)), 0);
      chk($sformatf("reset%0d done", i), longint'(g_done(i)), 0);
      chk($sformatf("reset%0d err", i), longint'(g_err(i)), 0);
    end

    tbl.push_back('{0, 32'd144,        12,    0,      1'b0});
    tbl.push_back('{0, 32'd65535,      255,   510,    1'b0});
    tbl.push_back('{0, 32'd0,          0,     0,      1'b0});
    tbl.push_back('{0, 32'd2,          1,     1,      1'b0});
    tbl.push_back('{0, 32'd50,         7,     1,      1'b0});
    tbl.push_back('{0, 32'h8000,       181,   7,      1'b0});
    tbl.push_back('{1, 32'hFFFF_FFFF,  65535, 131070, 1'b0});
    tbl.push_back('{1, 32'hFFFE_0001,  65535, 0,      1'b0});
    tbl.push_back('{2, 32'h8000,       0,     0,      1'b1});
    tbl.push_back('{2, 32'd81,         9,     0,      1'b0});
    tbl.push_back('{2, 32'h7FFF,       181,   6,      1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      op(tbl[i].inst, tbl[i].din, tbl[i].res, tbl[i].rem, tbl[i].err, $sformatf("tbl%0d", i));
    end

    // start held high across three operations; data moves while busy.
    @(negedge clk);
    start_a = 1'b1;
    data_a  = 16'd99;
    ndone   = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 1)  data_a = 16'd100;
      if (c == 11) data_a = 16'd101;
      if (c == 30) start_a = 1'b0;
      if (done_a) begin
        if (ndone < 3) begin
          chk($sformatf("b2b%0d done_cycle", ndone), c, b2b_cyc[ndone]);
          chk($sformatf("b2b%0d result", ndone), longint'(res_a), b2b_res[ndone]);
          chk($sformatf("b2b%0d remainder", ndone), longint'(rem_a), b2b_rem[ndone]);
        end
        ndone++;
      end
    end
    chk("b2b done_count", ndone, 3);

    // Reset asserted in cycle 5 of an operation.
    @(negedge clk);
    drive(0, 1'b1, 32'd1000);
    ndone = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) drive(0, 1'b0, 32'd1000);
      if (c == 5) rst_a = 1'b1;
      if (c == 6) begin
        chk("midrst result", longint'(res_a), 0);
        chk("midrst remainder", longint'(rem_a), 0);
        chk("midrst busy", longint'(busy_a), 0);
        chk("midrst done", longint'(done_a), 0);
        chk("midrst err", longint'(err_a), 0);
        rst_a = 1'b0;
      end
      if (done_a) ndone++;
    end
    chk("midrst no_done", ndone, 0);
    op(0, 32'd1000, 31, 39, 1'b0, "post_rst");

    for (int i = 0; i < 12; i++) begin
      v = 32'($urandom_range(0, 65535));
      op(0, v, isqrt(longint'(v)), longint'(v) - isqrt(longint'(v)) ** 2, 1'b0,
         $sformatf("rnd16_%0d", i));
    end
    for (int i = 0; i < 20; i++) begin
      v = $urandom;
      if (i == 0) v = 32'h0;
      if (i == 1) v = 32'hFFFE_0000;
      op(1, v, isqrt(longint'(v)), longint'(v) - isqrt(longint'(v)) ** 2, 1'b0,
         $sformatf("rnd32_%0d", i));
    end
    for (int i = 0; i < 12; i++) begin
      v = 32'($urandom_range(0, 65535));
      if (v[15]) op(2, v, 0, 0, 1'b1, $sformatf("rnds_%0d", i));
      else op(2, v, isqrt(longint'(v)), longint'(v) - isqrt(longint'(v)) ** 2, 1'b0,
              $sformatf("rnds_%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
